// File: rtl/brg_pkg.sv
//==============================================================================
// brg_pkg : shared types and defaults for the brg_prog generator.  Rev 1.0
//==============================================================================
`default_nettype none

package brg_pkg;

  typedef enum logic [0:0] {
    BRG_IDLE = 1'b0,
    BRG_RUN  = 1'b1
  } brg_state_t;

  localparam int BRG_CNT_W   = 16;
  localparam int BRG_OVS     = 16;
  localparam int BRG_DIV_RST = 2;
  localparam int BRG_FRAC_W  = 4;

endpackage

`default_nettype wire

// File: rtl/brg_prog_if.sv
//==============================================================================
// brg_prog_if : control/status bundle between a host and brg_prog.  Rev 1.0
//==============================================================================
`default_nettype none

interface brg_prog_if
  import brg_pkg::*;
#(
  parameter int CNT_W = BRG_CNT_W
);
  logic                  en;
  logic                  div_wr;
  logic [CNT_W-1:0]      div_in;
  logic [BRG_FRAC_W-1:0] frac_in;
  logic [CNT_W-1:0]      div_q;
  logic                  div_pend;
  logic                  tick_ovs;
  logic                  tick_baud;
  logic                  clk_out;

  modport master (
    output en, div_wr, div_in, frac_in,
    input  div_q, div_pend, tick_ovs, tick_baud, clk_out
  );

  modport slave (
    input  en, div_wr, div_in, frac_in,
    output div_q, div_pend, tick_ovs, tick_baud, clk_out
  );
endinterface

`default_nettype wire

// File: rtl/brg_tick_cnt.sv
//==============================================================================
// brg_tick_cnt : modulo-Neff tick counter, pending divisor and optional
// fractional trim (BRG_FRAC_EN).  Rev 1.0
//==============================================================================
`default_nettype none

module brg_tick_cnt
  import brg_pkg::*;
#(
  parameter int CNT_W   = BRG_CNT_W,
  parameter int DIV_RST = BRG_DIV_RST
)(
  input  wire logic                  Sys_clk,
  input  wire logic                  reset,
  input  wire logic                  i_en,
  input  wire logic                  i_run,
  input  wire logic                  i_div_wr,
  input  wire logic [CNT_W-1:0]      i_div_in,
  input  wire logic [BRG_FRAC_W-1:0] i_frac_in,
  output logic                       o_wrap,
  output logic [CNT_W-1:0]           o_div_q,
  output logic                       o_div_pend
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div_q;
  logic [CNT_W-1:0] r_pend_val;
  logic             r_pend;
  logic [CNT_W-1:0] w_n;
  logic             w_stretch;

  assign w_n    = (r_div_q == '0) ? CNT_W'(1) : r_div_q;
  // A stretched period ends one count later (terminal count N instead of N-1).
  assign o_wrap = i_en && (r_cnt == (w_stretch ? w_n : w_n - 1'b1));

`ifdef BRG_FRAC_EN
  logic [BRG_FRAC_W-1:0] r_acc;
  logic                  r_stretch;
  logic [BRG_FRAC_W:0]   w_acc_sum;

  assign w_acc_sum = {1'b0, r_acc} + {1'b0, i_frac_in};
  assign w_stretch = r_stretch;

  always_ff @(posedge Sys_clk) begin
    if (!reset || !i_en) begin
      r_acc     <= '0;
      r_stretch <= 1'b0;
    end else if (o_wrap) begin
      r_acc     <= w_acc_sum[BRG_FRAC_W-1:0];
      r_stretch <= w_acc_sum[BRG_FRAC_W];
    end
  end
`else
  logic w_unused_frac;
  assign w_unused_frac = ^i_frac_in;
  assign w_stretch     = 1'b0;
`endif

  always_ff @(posedge Sys_clk) begin
    if (!reset || !i_en || o_wrap) r_cnt <= '0;
    else                           r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge Sys_clk) begin
    if (!reset) begin
      r_div_q    <= CNT_W'(DIV_RST);
      r_pend     <= 1'b0;
      r_pend_val <= '0;
    end else if (!i_run) begin
      if (i_div_wr) r_div_q <= i_div_in;
      r_pend <= 1'b0;
    end else if (!i_en || o_wrap) begin
      // Leaving RUN or reaching a period boundary: commit the newest value.
      if (i_div_wr)    r_div_q <= i_div_in;
      else if (r_pend) r_div_q <= r_pend_val;
      r_pend <= 1'b0;
    end else if (i_div_wr) begin
      r_pend_val <= i_div_in;
      r_pend     <= 1'b1;
    end
  end

  assign o_div_q    = r_div_q;
  assign o_div_pend = r_pend;

endmodule

`default_nettype wire

// File: rtl/brg_prog.sv
//==============================================================================
// brg_prog : programmable oversample/baud strobe and square-clock generator.
// Optional fractional trim with BRG_FRAC_EN.  Rev 1.0
//==============================================================================
`default_nettype none

module brg_prog
  import brg_pkg::*;
#(
  parameter int CNT_W   = BRG_CNT_W,
  parameter int OVS     = BRG_OVS,
  parameter int DIV_RST = BRG_DIV_RST
)(
  input  wire logic Sys_clk,
  input  wire logic reset,
  brg_prog_if.slave bus
);

  localparam logic [0:0] ST_IDLE  = BRG_IDLE;
  localparam logic [0:0] ST_RUN   = BRG_RUN;
  localparam int         OVS_W    = (OVS > 1) ? $clog2(OVS) : 1;
  localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVS - 1);

  logic [0:0]       r_state;
  logic [OVS_W-1:0] r_ovs;
  logic             r_tick_ovs;
  logic             r_tick_baud;
  logic             r_clk_out;
  logic             w_wrap;
  logic [CNT_W-1:0] w_div_q;
  logic             w_div_pend;

  brg_tick_cnt #(
    .CNT_W   (CNT_W),
    .DIV_RST (DIV_RST)
  ) u_tick_cnt (
    .Sys_clk    (Sys_clk),
    .reset      (reset),
    .i_en       (bus.en),
    .i_run      (r_state == ST_RUN),
    .i_div_wr   (bus.div_wr),
    .i_div_in   (bus.div_in),
    .i_frac_in  (bus.frac_in),
    .o_wrap     (w_wrap),
    .o_div_q    (w_div_q),
    .o_div_pend (w_div_pend)
  );

  always_ff @(posedge Sys_clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_ovs       <= '0;
      r_tick_ovs  <= 1'b0;
      r_tick_baud <= 1'b0;
      r_clk_out   <= 1'b0;
    end else begin
      r_state <= bus.en ? ST_RUN : ST_IDLE;
      if (!bus.en) begin
        r_ovs       <= '0;
        r_tick_ovs  <= 1'b0;
        r_tick_baud <= 1'b0;
        r_clk_out   <= 1'b0;
      end else begin
        r_tick_ovs  <= w_wrap;
        r_tick_baud <= w_wrap && (r_ovs == OVS_LAST);
        if (w_wrap) begin
          r_ovs     <= (r_ovs == OVS_LAST) ? '0 : r_ovs + 1'b1;
          r_clk_out <= ~r_clk_out;
        end
      end
    end
  end

  assign bus.div_q     = w_div_q;
  assign bus.div_pend  = w_div_pend;
  assign bus.tick_ovs  = r_tick_ovs;
  assign bus.tick_baud = r_tick_baud;
  assign bus.clk_out   = r_clk_out;

endmodule

`default_nettype wire
